// File: rtl/sm4_rk_server_if.sv
// Key-load and round-key read bus between the encdec pipeline (master) and the
// SM4 round-key server (slave).
interface sm4_rk_server_if #(
    parameter int WORD_WIDTH   = 32,
    parameter int PIPE_DEPTH   = 4,
    parameter int ADDR_WIDTH   = 5,
    parameter int BLOCK_LENGTH = 128
);
    logic                             key_valid;
    logic [BLOCK_LENGTH-1:0]          key;
    logic                             key_ready;
    logic                             rk_ready;
    logic                             expand_done;
    logic [ADDR_WIDTH*PIPE_DEPTH-1:0] rk_addr;
    logic [WORD_WIDTH*PIPE_DEPTH-1:0] rk;

    modport master (
        output key_valid, key, rk_addr,
        input  key_ready, rk_ready, expand_done, rk
    );

    modport slave (
        input  key_valid, key, rk_addr,
        output key_ready, rk_ready, expand_done, rk
    );
endinterface

// File: rtl/sm4_rk_server.sv
// SM4 key expansion (one round per clock) into a 32-entry round-key store,
// served to PIPE_DEPTH independent combinational read lanes.
//
// state    | meaning
// S_IDLE   | no key loaded yet, waiting for key_valid
// S_EXPAND | computing rk[r_cnt] each clock, new keys ignored
// S_READY  | full round-key set valid, key_valid starts a rekey
module sm4_rk_server #(
    parameter int KEY_EXPAND_NUM = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int PIPE_DEPTH     = 4,
    parameter int ADDR_WIDTH     = 5,
    parameter int BLOCK_LENGTH   = 128
) (
    input logic            clk,
    input logic            rst_n,
    sm4_rk_server_if.slave if_rk
);
    localparam int IDX_W = $clog2(KEY_EXPAND_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KEY_EXPAND_NUM - 1);

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    localparam logic [7:0] SBOX [256] = '{
        8'hD6, 8'h90, 8'hE9, 8'hFE, 8'hCC, 8'hE1, 8'h3D, 8'hB7, 8'h16, 8'hB6, 8'h14, 8'hC2, 8'h28, 8'hFB, 8'h2C, 8'h05,
        8'h2B, 8'h67, 8'h9A, 8'h76, 8'h2A, 8'hBE, 8'h04, 8'hC3, 8'hAA, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
        8'h9C, 8'h42, 8'h50, 8'hF4, 8'h91, 8'hEF, 8'h98, 8'h7A, 8'h33, 8'h54, 8'h0B, 8'h43, 8'hED, 8'hCF, 8'hAC, 8'h62,
        8'hE4, 8'hB3, 8'h1C, 8'hA9, 8'hC9, 8'h08, 8'hE8, 8'h95, 8'h80, 8'hDF, 8'h94, 8'hFA, 8'h75, 8'h8F, 8'h3F, 8'hA6,
        8'h47, 8'h07, 8'hA7, 8'hFC, 8'hF3, 8'h73, 8'h17, 8'hBA, 8'h83, 8'h59, 8'h3C, 8'h19, 8'hE6, 8'h85, 8'h4F, 8'hA8,
        8'h68, 8'h6B, 8'h81, 8'hB2, 8'h71, 8'h64, 8'hDA, 8'h8B, 8'hF8, 8'hEB, 8'h0F, 8'h4B, 8'h70, 8'h56, 8'h9D, 8'h35,
        8'h1E, 8'h24, 8'h0E, 8'h5E, 8'h63, 8'h58, 8'hD1, 8'hA2, 8'h25, 8'h22, 8'h7C, 8'h3B, 8'h01, 8'h21, 8'h78, 8'h87,
        8'hD4, 8'h00, 8'h46, 8'h57, 8'h9F, 8'hD3, 8'h27, 8'h52, 8'h4C, 8'h36, 8'h02, 8'hE7, 8'hA0, 8'hC4, 8'hC8, 8'h9E,
        8'hEA, 8'hBF, 8'h8A, 8'hD2, 8'h40, 8'hC7, 8'h38, 8'hB5, 8'hA3, 8'hF7, 8'hF2, 8'hCE, 8'hF9, 8'h61, 8'h15, 8'hA1,
        8'hE0, 8'hAE, 8'h5D, 8'hA4, 8'h9B, 8'h34, 8'h1A, 8'h55, 8'hAD, 8'h93, 8'h32, 8'h30, 8'hF5, 8'h8C, 8'hB1, 8'hE3,
        8'h1D, 8'hF6, 8'hE2, 8'h2E, 8'h82, 8'h66, 8'hCA, 8'h60, 8'hC0, 8'h29, 8'h23, 8'hAB, 8'h0D, 8'h53, 8'h4E, 8'h6F,
        8'hD5, 8'hDB, 8'h37, 8'h45, 8'hDE, 8'hFD, 8'h8E, 8'h2F, 8'h03, 8'hFF, 8'h6A, 8'h72, 8'h6D, 8'h6C, 8'h5B, 8'h51,
        8'h8D, 8'h1B, 8'hAF, 8'h92, 8'hBB, 8'hDD, 8'hBC, 8'h7F, 8'h11, 8'hD9, 8'h5C, 8'h41, 8'h1F, 8'h10, 8'h5A, 8'hD8,
        8'h0A, 8'hC1, 8'h31, 8'h88, 8'hA5, 8'hCD, 8'h7B, 8'hBD, 8'h2D, 8'h74, 8'hD0, 8'h12, 8'hB8, 8'hE5, 8'hB4, 8'hB0,
        8'h89, 8'h69, 8'h97, 8'h4A, 8'h0C, 8'h96, 8'h77, 8'h7E, 8'h65, 8'hB9, 8'hF1, 8'h09, 8'hC5, 8'h6E, 8'hC6, 8'h84,
        8'h18, 8'hF0, 8'h7D, 8'hEC, 8'h3A, 8'hDC, 8'h4D, 8'h20, 8'h79, 8'hEE, 8'h5F, 8'h3E, 8'hD7, 8'hCB, 8'h39, 8'h48
    };

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_READY  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_last;
    logic             r_expand_done;
    logic [IDX_W-1:0] r_cnt;
    logic [31:0]      r_k [4];
    logic [31:0]      r_rk_mem [KEY_EXPAND_NUM];

    logic [7:0]       w_ck_base;
    logic [31:0]      w_ck;
    logic [31:0]      w_x;
    logic [31:0]      w_tau;
    logic [31:0]      w_new;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE, S_READY: begin
                if (if_rk.key_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXPAND;
                end
            end
            S_EXPAND: begin
                if (r_cnt == LAST_IDX) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_READY;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // CK bytes are (4i+j)*7 mod 256; 8-bit arithmetic does the modulo for free
    always_comb begin
        w_ck_base = 8'({r_cnt, 2'b00});
        w_ck      = {w_ck_base * 8'd7, (w_ck_base + 8'd1) * 8'd7,
                     (w_ck_base + 8'd2) * 8'd7, (w_ck_base + 8'd3) * 8'd7};
        w_x       = r_k[1] ^ r_k[2] ^ r_k[3] ^ w_ck;
        w_tau     = {SBOX[w_x[31:24]], SBOX[w_x[23:16]], SBOX[w_x[15:8]], SBOX[w_x[7:0]]};
        w_new     = r_k[0] ^ w_tau ^ {w_tau[18:0], w_tau[31:19]} ^ {w_tau[8:0], w_tau[31:9]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_expand_done <= 1'b0;
            r_cnt         <= '0;
            for (int i = 0; i < 4; i++) r_k[i] <= '0;
            for (int i = 0; i < KEY_EXPAND_NUM; i++) r_rk_mem[i] <= '0;
        end else begin
            r_expand_done <= w_last;
            if (w_accept) begin
                r_k[0] <= if_rk.key[127:96] ^ FK0;
                r_k[1] <= if_rk.key[95:64]  ^ FK1;
                r_k[2] <= if_rk.key[63:32]  ^ FK2;
                r_k[3] <= if_rk.key[31:0]   ^ FK3;
                r_cnt  <= '0;
            end else if (r_state == S_EXPAND) begin
                r_rk_mem[r_cnt] <= w_new;
                r_k[0]          <= r_k[1];
                r_k[1]          <= r_k[2];
                r_k[2]          <= r_k[3];
                r_k[3]          <= w_new;
                r_cnt           <= r_cnt + 1'b1;
            end
        end
    end

    assign if_rk.key_ready   = (r_state != S_EXPAND);
    assign if_rk.rk_ready    = (r_state == S_READY);
    assign if_rk.expand_done = r_expand_done;

    // Lanes read ungated; the consumer waits for rk_ready before trusting them
    for (genvar g = 0; g < PIPE_DEPTH; g++) begin : g_lane
        logic [ADDR_WIDTH-1:0] w_addr;
        assign w_addr = if_rk.rk_addr[ADDR_WIDTH*g +: ADDR_WIDTH];
        assign if_rk.rk[WORD_WIDTH*g +: WORD_WIDTH] =
            ({{(32-ADDR_WIDTH){1'b0}}, w_addr} < 32'(KEY_EXPAND_NUM))
                ? r_rk_mem[w_addr[IDX_W-1:0]] : '0;
    end
endmodule

// File: tb/tb_sm4_rk_server.sv
// Scoreboard bench for sm4_rk_server: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_sm4_rk_server;
    localparam logic [127:0] KSTD = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] KA   = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] KB   = 128'hFFEEDDCCBBAA99887766554433221100;

    localparam logic [2047:0] SBOX_M = {
        128'hD690E9FECCE13DB716B614C228FB2C05, 128'h2B679A762ABE04C3AA44132649860699,
        128'h9C4250F491EF987A33540B43EDCFAC62, 128'hE4B31CA9C908E89580DF94FA758F3FA6,
        128'h4707A7FCF37317BA83593C19E6854FA8, 128'h686B81B27164DA8BF8EB0F4B70569D35,
        128'h1E240E5E6358D1A225227C3B01217887, 128'hD40046579FD327524C3602E7A0C4C89E,
        128'hEABF8AD240C738B5A3F7F2CEF96115A1, 128'hE0AE5DA49B341A55AD933230F58CB1E3,
        128'h1DF6E22E8266CA60C02923AB0D534E6F, 128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
        128'h8D1BAF92BBDDBC7F11D95C411F105AD8, 128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
        128'h8969974A0C96777E65B9F109C56EC684, 128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
    };

    localparam int K_KRDY = 4, K_RRDY = 5, K_DONE = 6, K_L6 = 7;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic [31:0] m_rk[32];
    logic [31:0] g_std[32];
    logic [31:0] g_a[32];
    logic [31:0] g_z[32];

    sm4_rk_server_if #(.ADDR_WIDTH(5)) u_if ();
    sm4_rk_server_if #(.ADDR_WIDTH(6)) u_if6 ();

    sm4_rk_server #(.ADDR_WIDTH(5)) u_dut (.clk(clk), .rst_n(rst_n), .if_rk(u_if));
    sm4_rk_server #(.ADDR_WIDTH(6)) u_dut6 (.clk(clk), .rst_n(rst_n), .if_rk(u_if6));

    assign u_if6.key_valid = u_if.key_valid;
    assign u_if6.key       = u_if.key;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic logic [7:0] sbox_m(input int b);
        return SBOX_M[2047 - 8*b -: 8];
    endfunction

    task automatic build_model(input logic [127:0] mk);
        logic [31:0] k[4];
        logic [31:0] x, t, ck;
        k[0] = mk[127:96] ^ 32'hA3B1BAC6;
        k[1] = mk[95:64]  ^ 32'h56AA3350;
        k[2] = mk[63:32]  ^ 32'h677D9197;
        k[3] = mk[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            ck = 0;
            for (int j = 0; j < 4; j++) ck = (ck << 8) | 32'(((4*i + j) * 7) % 256);
            x = k[1] ^ k[2] ^ k[3] ^ ck;
            t = 0;
            for (int j = 3; j >= 0; j--) t = (t << 8) | 32'(sbox_m(int'(x[8*j +: 8])));
            t = t ^ rotl(t, 13) ^ rotl(t, 23);
            m_rk[i] = k[0] ^ t;
            k[0] = k[1]; k[1] = k[2]; k[2] = k[3]; k[3] = m_rk[i];
        end
    endtask

    function automatic logic [31:0] gold(input int sel, input int idx);
        case (sel)
            0:       return g_std[idx];
            1:       return g_a[idx];
            default: return g_z[idx];
        endcase
    endfunction

    function automatic string kname(input int kind);
        case (kind)
            K_KRDY:  return "key_ready";
            K_RRDY:  return "rk_ready";
            K_DONE:  return "expand_done";
            default: return (kind < K_L6) ? $sformatf("rk_lane%0d", kind)
                                          : $sformatf("rk6_lane%0d", kind - K_L6);
        endcase
    endfunction

    function automatic logic [31:0] pick(input int kind);
        case (kind)
            K_KRDY:  return {31'b0, u_if.key_ready};
            K_RRDY:  return {31'b0, u_if.rk_ready};
            K_DONE:  return {31'b0, u_if.expand_done};
            default: return (kind < K_L6) ? u_if.rk[32*kind +: 32] : u_if6.rk[32*(kind-K_L6) +: 32];
        endcase
    endfunction

    always @(negedge clk) begin
        logic [31:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checks++;
                act = pick(sb[i].kind);
                if (act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s cyc %0d: got %08h expected %08h", kname(sb[i].kind), cyc, act, sb[i].exp);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL %s stale at cyc %0d: got none expected %08h", kname(sb[i].kind), sb[i].cyc, sb[i].exp);
                sb.delete(i);
            end
        end
    end

    task automatic push(input int at, input int kind, input logic [31:0] exp);
        exp_t e;
        e.cyc = at; e.kind = kind; e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int a0, input int a1, input int a2, input int a3);
        u_if.rk_addr = {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endtask

    task automatic set_lanes6(input int a0, input int a1, input int a2, input int a3);
        u_if6.rk_addr = {6'(a3), 6'(a2), 6'(a1), 6'(a0)};
    endtask

    // Present a key for one cycle and queue the handshake profile; returns at accept+32
    task automatic start(input logic [127:0] k, input bit inject, input bit from_ready, output int c0);
        c0 = cyc;
        u_if.key       = k;
        u_if.key_valid = 1'b1;
        push(c0, K_KRDY, 32'd1);
        push(c0, K_RRDY, {31'b0, from_ready});
        for (int i = 1; i <= 32; i++) begin
            push(c0 + i, K_KRDY, 32'd0);
            push(c0 + i, K_RRDY, 32'd0);
            push(c0 + i, K_DONE, 32'd0);
        end
        push(c0 + 33, K_KRDY, 32'd1);
        push(c0 + 33, K_RRDY, 32'd1);
        push(c0 + 33, K_DONE, 32'd1);
        push(c0 + 34, K_DONE, 32'd0);
        tick();
        u_if.key_valid = 1'b0;
        while (cyc < c0 + 33) begin
            if (inject && (cyc == c0 + 5 || cyc == c0 + 20)) begin
                u_if.key       = KB;
                u_if.key_valid = 1'b1;
            end
            tick();
            u_if.key_valid = 1'b0;
        end
    endtask

    task automatic readout_all(input int sel);
        for (int r = 0; r < 8; r++) begin
            set_lanes(4*r, 4*r + 1, 4*r + 2, 4*r + 3);
            for (int l = 0; l < 4; l++) push(cyc, l, gold(sel, 4*r + l));
            tick();
        end
    endtask

    initial begin
        int c0;
        build_model(KSTD); g_std = m_rk;
        build_model(KA);   g_a   = m_rk;
        build_model('0);   g_z   = m_rk;

        rst_n = 1'b0;
        u_if.key_valid = 1'b0;
        u_if.key = '0;
        set_lanes(0, 31, 5, 17);
        set_lanes6(0, 40, 31, 63);
        tick();
        tick();
        push(cyc, K_KRDY, 32'd1);
        push(cyc, K_RRDY, 32'd0);
        push(cyc, K_DONE, 32'd0);
        for (int l = 0; l < 4; l++) push(cyc, l, 32'd0);
        push(cyc, K_L6, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // standard vector, lanes 0,1,31,30
        start(KSTD, 1'b0, 1'b0, c0);
        set_lanes(0, 1, 31, 30);
        push(cyc, 0, 32'hF12186F9);
        push(cyc, 1, 32'h41662B61);
        push(cyc, 2, 32'h9124A012);
        push(cyc, 3, g_std[30]);
        set_lanes6(40, 5, 32, 63);
        push(cyc, K_L6 + 0, 32'd0);
        push(cyc, K_L6 + 1, g_std[5]);
        push(cyc, K_L6 + 2, 32'd0);
        push(cyc, K_L6 + 3, 32'd0);
        tick();

        // decrypt-order sweep on lane 0, encrypt-order on lane 3
        for (int k = 0; k < 32; k++) begin
            set_lanes(31 - k, (k + 7) % 32, (k * 3) % 32, k);
            push(cyc, 0, g_std[31 - k]);
            push(cyc, 1, g_std[(k + 7) % 32]);
            push(cyc, 2, g_std[(k * 3) % 32]);
            push(cyc, 3, g_std[k]);
            tick();
        end

        // key_valid pulses during EXPAND must be ignored
        start(KA, 1'b1, 1'b1, c0);
        readout_all(1);

        // rekey with all-zero key from READY
        start('0, 1'b0, 1'b1, c0);
        set_lanes(0, 0, 17, 31);
        push(cyc, 0, g_z[0]);
        push(cyc, 1, g_z[0]);
        push(cyc, 2, g_z[17]);
        push(cyc, 3, g_z[31]);
        tick();

        // reset mid-expansion discards everything
        c0 = cyc;
        u_if.key = KSTD;
        u_if.key_valid = 1'b1;
        tick();
        u_if.key_valid = 1'b0;
        while (cyc < c0 + 10) begin
            push(cyc, K_KRDY, 32'd0);
            tick();
        end
        rst_n = 1'b0;
        push(cyc, K_KRDY, 32'd1);
        push(cyc, K_RRDY, 32'd0);
        push(cyc, K_DONE, 32'd0);
        for (int r = 0; r < 8; r++) begin
            set_lanes(4*r, 4*r + 1, 4*r + 2, 4*r + 3);
            set_lanes6(4*r, 4*r + 1, 4*r + 2, 4*r + 3);
            for (int l = 0; l < 4; l++) begin
                push(cyc, l, 32'd0);
                push(cyc, K_L6 + l, 32'd0);
            end
            tick();
        end
        rst_n = 1'b1;
        tick();
        start(KA, 1'b0, 1'b0, c0);
        readout_all(1);

        tick();
        tick();
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s never compared: got none expected %08h", kname(sb[0].kind), sb[0].exp);
            void'(sb.pop_front());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
